// File: rtl/hist_pkg.sv
// Shared types and helpers for the multi-channel histogram engine.
package hist_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int unsigned DEF_COUNT_WIDTH = 16;
    localparam logic [DEF_COUNT_WIDTH-1:0] COUNT_MAX = '1;

    // {channel, bin} with out-of-range values folded into the top bin of the channel.
    function automatic logic [31:0] bin_addr(input logic [31:0] ch,
                                             input logic [31:0] value,
                                             input int unsigned bin_w);
        logic [31:0] top_bin;
        logic [31:0] bin;
        top_bin = (32'd1 << bin_w) - 32'd1;
        bin     = (value > top_bin) ? top_bin : value;
        return (ch << bin_w) | bin;
    endfunction

endpackage

// File: rtl/hist_dpram.sv
// Dual-port bin RAM: port A read+write for the increment path (read-old-during-write),
// port B read-only for the PC. Both read outputs are registered.
module hist_dpram #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_waddr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic [ADDR_WIDTH-1:0] a_raddr,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] a_rdata_d, a_rdata_q;
    logic [DATA_WIDTH-1:0] b_rdata_d, b_rdata_q;

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem_q[a_waddr] <= a_wdata;
        end
    end

    always_comb begin
        a_rdata_d = mem_q[a_raddr];
        b_rdata_d = mem_q[b_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/hist_multichan_engine.sv
// Multi-channel histogram engine: 1 sample/clk bin increment with write forwarding,
// PC read port and RAM clear sweep. Define HIST_SATURATE_EN for saturating counters.
module hist_multichan_engine
    import hist_pkg::*;
#(
    parameter int unsigned CH_WIDTH    = 2,
    parameter int unsigned BIN_WIDTH   = 9,
    parameter int unsigned VALUE_WIDTH = 16,
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH  = CH_WIDTH + BIN_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [CH_WIDTH-1:0]    s_channel,
    input  logic [VALUE_WIDTH-1:0] s_value,
    input  logic                   clear_req,
    output logic                   hist_ready,
    input  logic [ADDR_WIDTH-1:0]  pc_rd_addr,
    output logic [COUNT_WIDTH-1:0] pc_rd_data,
    output logic                   sat_flag
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  sweep_addr_q, sweep_addr_d;
    logic                   s_ready_q, s_ready_d;
    logic                   hist_ready_q, hist_ready_d;
    logic                   p_valid_q, p_valid_d;
    logic [ADDR_WIDTH-1:0]  p_addr_q, p_addr_d;
    logic                   wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [COUNT_WIDTH-1:0] wr_data_q, wr_data_d;

    logic                   accept;
    logic [ADDR_WIDTH-1:0]  samp_addr;
    logic                   fwd_hit;
    logic [COUNT_WIDTH-1:0] q_a;
    logic [COUNT_WIDTH-1:0] base;
    logic [COUNT_WIDTH-1:0] inc;
    logic                   ram_we;
    logic [ADDR_WIDTH-1:0]  ram_waddr;
    logic [COUNT_WIDTH-1:0] ram_wdata;

    assign accept    = s_valid & s_ready_q;
    assign samp_addr = ADDR_WIDTH'(bin_addr(32'(s_channel), 32'(s_value), BIN_WIDTH));

    // RAM returns old data when the previous cycle's write hit the same bin.
    always_comb begin
        fwd_hit = wr_valid_q && (wr_addr_q == p_addr_q);
        base    = fwd_hit ? wr_data_q : q_a;
`ifdef HIST_SATURATE_EN
        inc     = (&base) ? base : base + COUNT_WIDTH'(1);
`else
        inc     = base + COUNT_WIDTH'(1);
`endif
    end

    always_comb begin
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        ram_we       = 1'b0;
        ram_waddr    = p_addr_q;
        ram_wdata    = inc;
        case (state_q)
            ST_CLEAR: begin
                ram_we       = 1'b1;
                ram_waddr    = sweep_addr_q;
                ram_wdata    = '0;
                sweep_addr_d = sweep_addr_q + ADDR_WIDTH'(1);
                if (clear_req) begin
                    sweep_addr_d = '0;
                end else if (sweep_addr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                ram_we = p_valid_q;
                if (clear_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                ram_we       = p_valid_q;
                sweep_addr_d = '0;
                state_d      = ST_CLEAR;
            end
            default: begin
                state_d      = ST_CLEAR;
                sweep_addr_d = '0;
            end
        endcase
        s_ready_d    = (state_d == ST_RUN);
        hist_ready_d = (state_d != ST_CLEAR);
        p_valid_d    = accept;
        p_addr_d     = samp_addr;
        wr_valid_d   = p_valid_q && (state_q != ST_CLEAR);
        wr_addr_d    = p_addr_q;
        wr_data_d    = inc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_CLEAR;
            sweep_addr_q <= '0;
            s_ready_q    <= 1'b0;
            hist_ready_q <= 1'b0;
            p_valid_q    <= 1'b0;
            p_addr_q     <= '0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
            s_ready_q    <= s_ready_d;
            hist_ready_q <= hist_ready_d;
            p_valid_q    <= p_valid_d;
            p_addr_q     <= p_addr_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

`ifdef HIST_SATURATE_EN
    logic sat_q, sat_d;

    // Sticky until the engine re-enters the clear sweep.
    always_comb begin
        sat_d = sat_q | (p_valid_q && (&base));
        if (state_q == ST_DRAIN) begin
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`else
    assign sat_flag = 1'b0;
`endif

    hist_dpram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(COUNT_WIDTH)
    ) u_ram (
        .clk    (clk),
        .reset_n(reset_n),
        .a_we   (ram_we),
        .a_waddr(ram_waddr),
        .a_wdata(ram_wdata),
        .a_raddr(samp_addr),
        .a_rdata(q_a),
        .b_addr (pc_rd_addr),
        .b_rdata(pc_rd_data)
    );

    assign s_ready    = s_ready_q;
    assign hist_ready = hist_ready_q;

endmodule

// File: tb/tb_hist_multichan_engine.sv
// Directed self-checking bench: default-size engine plus a small 4-bit-count instance.
module tb_hist_multichan_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_valid;
    logic        s_ready;
    logic [1:0]  s_channel;
    logic [15:0] s_value;
    logic        clear_req;
    logic        hist_ready;
    logic [10:0] pc_rd_addr;
    logic [15:0] pc_rd_data;
    logic        sat_flag;

    logic        s4_valid;
    logic        s4_ready;
    logic [0:0]  s4_channel;
    logic [7:0]  s4_value;
    logic        clear4;
    logic        hist4_ready;
    logic [3:0]  pc4_addr;
    logic [3:0]  pc4_data;
    logic        sat4;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] val;
        int          n;
        logic [10:0] addr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    hist_multichan_engine dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_channel (s_channel),
        .s_value   (s_value),
        .clear_req (clear_req),
        .hist_ready(hist_ready),
        .pc_rd_addr(pc_rd_addr),
        .pc_rd_data(pc_rd_data),
        .sat_flag  (sat_flag)
    );

    hist_multichan_engine #(
        .CH_WIDTH   (1),
        .BIN_WIDTH  (3),
        .VALUE_WIDTH(8),
        .COUNT_WIDTH(4)
    ) dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid   (s4_valid),
        .s_ready   (s4_ready),
        .s_channel (s4_channel),
        .s_value   (s4_value),
        .clear_req (clear4),
        .hist_ready(hist4_ready),
        .pc_rd_addr(pc4_addr),
        .pc_rd_data(pc4_data),
        .sat_flag  (sat4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] ch, input logic [15:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            s_valid   = 1'b1;
            s_channel = ch;
            s_value   = val;
            step();
        end
        s_valid = 1'b0;
    endtask

    task automatic send4(input logic [0:0] ch, input logic [7:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            s4_valid   = 1'b1;
            s4_channel = ch;
            s4_value   = val;
            step();
        end
        s4_valid = 1'b0;
    endtask

    task automatic settle();
        step();
        step();
    endtask

    task automatic rd(input logic [10:0] a, output logic [15:0] d);
        pc_rd_addr = a;
        step();
        d = pc_rd_data;
    endtask

    task automatic rd4(input logic [3:0] a, output logic [3:0] d);
        pc4_addr = a;
        step();
        d = pc4_data;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (hist_ready !== 1'b1 && n < 5000) begin
            step();
            n++;
        end
    endtask

    task automatic all_zero(input string name);
        int bad;
        logic [15:0] d;
        bad = 0;
        for (int a = 0; a < 2048; a++) begin
            rd(11'(a), d);
            if (d !== 16'd0) bad++;
        end
        chk(name, 32'(bad), 32'd0);
    endtask

    initial begin
        int          n;
        logic [15:0] d;
        logic [3:0]  d4;

        vecs[0] = '{ch: 2'd1, val: 16'd5,      n: 3, addr: 11'h205, exp: 16'd3};
        vecs[1] = '{ch: 2'd0, val: 16'd5,      n: 0, addr: 11'h005, exp: 16'd0};
        vecs[2] = '{ch: 2'd2, val: 16'h1234,   n: 1, addr: 11'h5FF, exp: 16'd1};
        vecs[3] = '{ch: 2'd2, val: 16'd511,    n: 2, addr: 11'h5FF, exp: 16'd3};
        vecs[4] = '{ch: 2'd2, val: 16'd510,    n: 1, addr: 11'h5FE, exp: 16'd1};
        vecs[5] = '{ch: 2'd3, val: 16'd0,      n: 4, addr: 11'h600, exp: 16'd4};
        vecs[6] = '{ch: 2'd0, val: 16'hFFFF,   n: 1, addr: 11'h1FF, exp: 16'd1};
        vecs[7] = '{ch: 2'd1, val: 16'd5,      n: 1, addr: 11'h205, exp: 16'd4};
        vecs[8] = '{ch: 2'd1, val: 16'd512,    n: 1, addr: 11'h3FF, exp: 16'd1};

        reset_n    = 1'b0;
        s_valid    = 1'b0;
        s_channel  = '0;
        s_value    = '0;
        clear_req  = 1'b0;
        pc_rd_addr = '0;
        s4_valid   = 1'b0;
        s4_channel = '0;
        s4_value   = '0;
        clear4     = 1'b0;
        pc4_addr   = '0;

        repeat (3) step();
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_hist_ready", 32'(hist_ready), 32'd0);
        chk("rst_pc_rd_data", 32'(pc_rd_data), 32'd0);
        chk("rst_sat_flag", 32'(sat_flag), 32'd0);

        reset_n = 1'b1;
        wait_ready(n);
        chk("init_sweep_clks", 32'(n), 32'd2048);
        chk("run_s_ready", 32'(s_ready), 32'd1);
        chk("dut4_ready", 32'(hist4_ready), 32'd1);
        all_zero("init_all_zero");

        for (int i = 0; i < 9; i++) begin
            send(vecs[i].ch, vecs[i].val, vecs[i].n);
            settle();
            rd(vecs[i].addr, d);
            chk($sformatf("vec%0d", i), 32'(d), 32'(vecs[i].exp));
        end

        for (int i = 0; i < 100; i++) begin
            s_valid   = 1'b1;
            s_channel = 2'd3;
            s_value   = (i % 2 == 0) ? 16'd7 : 16'd8;
            step();
        end
        s_valid = 1'b0;
        settle();
        rd(11'h607, d);
        chk("alt_607", 32'(d), 32'd50);
        rd(11'h608, d);
        chk("alt_608", 32'(d), 32'd50);
        chk("no_sat_16b", 32'(sat_flag), 32'd0);

        // 11th sample accepted in the same cycle as clear_req must still land.
        send(2'd0, 16'd1, 10);
        s_valid   = 1'b1;
        s_channel = 2'd0;
        s_value   = 16'd1;
        clear_req = 1'b1;
        step();
        s_valid    = 1'b0;
        clear_req  = 1'b0;
        chk("drain_s_ready", 32'(s_ready), 32'd0);
        pc_rd_addr = 11'h001;
        step();
        chk("clear_hist_low", 32'(hist_ready), 32'd0);
        step();
        chk("inflight_kept", 32'(pc_rd_data), 32'd11);
        wait_ready(n);
        chk("drain_sweep_clks", 32'(n + 2), 32'd2049);
        all_zero("clear_all_zero");

        // clear_req during the sweep restarts it from address 0.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (101) step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        wait_ready(n);
        chk("restart_sweep_clks", 32'(n), 32'd2048);

        // Reset in the middle of a sweep.
        send(2'd1, 16'd5, 3);
        settle();
        rd(11'h205, d);
        chk("pre_reset_data", 32'(d), 32'd3);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (300) step();
        chk("partial_sweep_rd", 32'(pc_rd_data), 32'd3);
        reset_n = 1'b0;
        #2;
        chk("midrst_pc_rd_data", 32'(pc_rd_data), 32'd0);
        chk("midrst_hist_ready", 32'(hist_ready), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        step();
        reset_n = 1'b1;
        wait_ready(n);
        chk("midrst_sweep_clks", 32'(n), 32'd2048);
        rd(11'h205, d);
        chk("midrst_cleared", 32'(d), 32'd0);

        // Small instance: 4-bit counters, wrap or saturate.
        send4(1'b1, 8'd2, 20);
        settle();
        rd4(4'hA, d4);
`ifdef HIST_SATURATE_EN
        chk("cnt4_value", 32'(d4), 32'd15);
        chk("cnt4_sat", 32'(sat4), 32'd1);
`else
        chk("cnt4_value", 32'(d4), 32'd4);
        chk("cnt4_sat", 32'(sat4), 32'd0);
`endif
        send4(1'b0, 8'd9, 1);
        send4(1'b0, 8'd7, 1);
        settle();
        rd4(4'h7, d4);
        chk("cnt4_clamp", 32'(d4), 32'd2);
        clear4 = 1'b1;
        step();
        clear4 = 1'b0;
        repeat (20) step();
        chk("cnt4_ready", 32'(hist4_ready), 32'd1);
        chk("cnt4_sat_cleared", 32'(sat4), 32'd0);
        rd4(4'hA, d4);
        chk("cnt4_cleared", 32'(d4), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hist_multichan_engine.md
Name: hist_multichan_engine

Overview:
- Multi-channel histogram engine; next generation of the single-channel PWC histogram.
- Takes a valid/ready sample stream of (channel, value) from the PWC/FIFO side and increments bin {channel, value} in an internal dual-port RAM.
- Sustains 1 sample/clk using read-during-write forwarding, replacing the fixed FIFO wait.
- Second RAM port gives the PC read access; PC-requested clear sweeps the RAM.

Parameters:
- CH_WIDTH, 2, channel index width; NUM_CH = 2**CH_WIDTH.
- BIN_WIDTH, 9, bins per channel = 2**BIN_WIDTH.
- VALUE_WIDTH, 16, width of the incoming sample value (must be >= BIN_WIDTH).
- COUNT_WIDTH, 16, bin counter width.
- ADDR_WIDTH, CH_WIDTH+BIN_WIDTH, derived RAM address width; do not override.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- s_valid  in  1  sample valid
- s_ready  out  1  engine accepts a sample this cycle
- s_channel  in  CH_WIDTH  sample channel
- s_value  in  VALUE_WIDTH  sample value (pulse width)
- clear_req  in  1  single-cycle pulse from PC: zero all bins
- hist_ready  out  1  high once the RAM is cleared and the engine is in RUN
- pc_rd_addr  in  ADDR_WIDTH  PC bin address {channel, bin}
- pc_rd_data  out  COUNT_WIDTH  bin count, 1-cycle read latency
- sat_flag  out  1  sticky: some bin hit max (HIST_SATURATE_EN only; else tied 0)

Behaviour:
- Reset (reset_n=0, async): state=CLEAR, sweep addr=0, s_ready=0, hist_ready=0, pipeline valids=0, sat_flag=0, pc_rd_data=0.
- States:
  - CLEAR: write 0 to sweep addr, one word/clk. When addr = 2**ADDR_WIDTH-1 is written -> RUN, hist_ready=1. Sweep takes 2**ADDR_WIDTH clks.
  - RUN: s_ready=1. clear_req -> DRAIN.
  - DRAIN: 1 clk, s_ready=0, completes any in-flight write, then -> CLEAR with addr=0 and hist_ready=0.
- clear_req in CLEAR or DRAIN restarts the sweep at address 0.
- Bin mapping: bin = s_value if s_value < 2**BIN_WIDTH, else 2**BIN_WIDTH-1 (clamp overflow into top bin). addr = {s_channel, bin}.
- Pipeline: accept at cycle t (s_valid & s_ready); RAM port A read issued at t; addr/valid registered. At t+1: base = fwd_hit ? last_wr_data : q_a; write base+1 to addr at t+1.
  - fwd_hit = last write valid and last_wr_addr == current addr. Forwarding covers back-to-back samples to the same bin (RAM is read-old-during-write).
  - Accepted samples are never dropped, including one accepted in the cycle clear_req arrives.
- Arithmetic: increment is modulo 2**COUNT_WIDTH without the optional feature.
- PC port B: read-only. pc_rd_data = RAM[pc_rd_addr] one clk later. A bin written at t+1 is visible to a PC read issued at t+2 or later. Reads during CLEAR return the partially cleared contents; the PC qualifies them with hist_ready.

Optional Feature:
- Macro: HIST_SATURATE_EN.
- Defined: increment saturates at 2**COUNT_WIDTH-1; an increment attempt at max sets sat_flag. sat_flag is cleared only by reset or entry to CLEAR.
- Undefined: counters wrap; sat_flag tied 0.

Decomposition:
- Package hist_pkg: state encoding (CLEAR, RUN, DRAIN); the bin clamp/address-form function; COUNT_MAX constant.
- Sub-module hist_dpram: true dual-port RAM, depth 2**ADDR_WIDTH, width COUNT_WIDTH, registered outputs, read-old-during-write on port A; wraps the vendor on-chip memory.

Test Plan:
- Reset release -> s_ready=0 for 2048 clks (defaults), then hist_ready=1; reading all 2048 addresses returns 0.
- Ch1 value 5, 3 back-to-back samples -> pc_rd_addr=0x205 reads 3 (forwarding check); ch0 value 5 remains 0.
- Alternating ch3 val 7 / ch3 val 8, 100 samples -> addr 0x607=50, 0x608=50.
- s_value=0x1234 on ch2 -> clamped bin 511, addr 0x5FF=1.
- 10 samples, then clear_req in the same cycle as the 11th accepted sample -> 1 DRAIN clk, full sweep, all bins 0, hist_ready low for the sweep; reset_n asserted mid-sweep restarts the sweep from 0.
- HIST_SATURATE_EN, COUNT_WIDTH=4: 20 samples to one bin -> reads 15, sat_flag=1. Without the macro -> reads 4, sat_flag=0.
